reloj_param: RTL and testbench

Parametrised time-of-day counter for the pet game: it derives a seconds tick from the system clock and maintains sec/min/hour. Over a fixed-rate counter it adds a run/pause control, an accelerated "fast" mode, a synchronous time load, one-cycle rollover strobes and a programmable alarm strobe. The game FSM and display logic consume its counters and strobes.

---
 rtl/reloj_param.sv | 128 ++++++++++++
 tb/tb_reloj_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reloj_param.sv
// Time-of-day counter: derives a seconds tick from the system clock and keeps
// sec/min/hour with run/pause, fast mode, clamped load, rollover and alarm strobes.
module reloj_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int FAST_DIV  = 60,
    parameter int HOURS_MOD = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fast,
    input  logic       load,
    input  logic [5:0] load_sec,
    input  logic [5:0] load_min,
    input  logic [4:0] load_hour,
    input  logic       alarm_en,
    input  logic [5:0] alarm_min,
    input  logic [4:0] alarm_hour,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       tick_sec,
    output logic       tick_min,
    output logic       tick_hour,
    output logic       tick_day,
    output logic       alarm
);

    localparam int             PW       = $clog2(CLK_FREQ);
    localparam logic [PW-1:0]  SLOW_M1  = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0]  FAST_M1  = PW'(CLK_FREQ / FAST_DIV - 1);
    localparam logic [PW-1:0]  PRESC_1  = PW'(1);
    localparam logic [4:0]     HOUR_MAX = 5'(HOURS_MOD - 1);
    localparam logic [5:0]     HOUR_LIM = 6'(HOURS_MOD);

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          tick_sec_q, tick_sec_d;
    logic          tick_min_q, tick_min_d;
    logic          tick_hour_q, tick_hour_d;
    logic          tick_day_q, tick_day_d;
    logic          alarm_q, alarm_d;
    logic [PW-1:0] div_m1;

    assign div_m1 = fast ? FAST_M1 : SLOW_M1;

    always_comb begin
        presc_d     = presc_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        tick_sec_d  = 1'b0;
        tick_min_d  = 1'b0;
        tick_hour_d = 1'b0;
        tick_day_d  = 1'b0;
        alarm_d     = 1'b0;
        if (load) begin
            presc_d = '0;
            sec_d   = (load_sec > 6'd59) ? 6'd0 : load_sec;
            min_d   = (load_min > 6'd59) ? 6'd0 : load_min;
            hour_d  = ({1'b0, load_hour} >= HOUR_LIM) ? 5'd0 : load_hour;
        end else if (en) begin
            // >= so a switch into fast mode with a large prescaler wraps at once
            if (presc_q >= div_m1) begin
                presc_d    = '0;
                tick_sec_d = 1'b1;
                if (sec_q >= 6'd59) begin
                    sec_d      = 6'd0;
                    tick_min_d = 1'b1;
                    if (min_q >= 6'd59) begin
                        min_d       = 6'd0;
                        tick_hour_d = 1'b1;
                        if (hour_q >= HOUR_MAX) begin
                            hour_d     = 5'd0;
                            tick_day_d = 1'b1;
                        end else begin
                            hour_d = hour_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
                alarm_d = alarm_en && (sec_d == 6'd0) && (min_d == alarm_min)
                          && (hour_d == alarm_hour);
            end else begin
                presc_d = presc_q + PRESC_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            tick_sec_q  <= 1'b0;
            tick_min_q  <= 1'b0;
            tick_hour_q <= 1'b0;
            tick_day_q  <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            tick_sec_q  <= tick_sec_d;
            tick_min_q  <= tick_min_d;
            tick_hour_q <= tick_hour_d;
            tick_day_q  <= tick_day_d;
            alarm_q     <= alarm_d;
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign tick_sec  = tick_sec_q;
    assign tick_min  = tick_min_q;
    assign tick_hour = tick_hour_q;
    assign tick_day  = tick_day_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_reloj_param.sv
// Directed bench for reloj_param with CLK_FREQ=10, FAST_DIV=5 (fast period 2), HOURS_MOD=24.
module tb_reloj_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       fast;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hour;
    logic       alarm_en;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       tick_sec;
    logic       tick_min;
    logic       tick_hour;
    logic       tick_day;
    logic       alarm;

    int vectors;
    int miscompares;

    reloj_param #(
        .CLK_FREQ (10),
        .FAST_DIV (5),
        .HOURS_MOD(24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fast      (fast),
        .load      (load),
        .load_sec  (load_sec),
        .load_min  (load_min),
        .load_hour (load_hour),
        .alarm_en  (alarm_en),
        .alarm_min (alarm_min),
        .alarm_hour(alarm_hour),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .tick_sec  (tick_sec),
        .tick_min  (tick_min),
        .tick_hour (tick_hour),
        .tick_day  (tick_day),
        .alarm     (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Time packed as {hour, min, sec}; strobes as {tick_sec, tick_min, tick_hour, tick_day, alarm}.
    task automatic checkOutput(input string tag, input logic [16:0] exp_time,
                               input logic [4:0] exp_strobes);
        logic [21:0] observed;
        logic [21:0] expected;
        observed = {hour, min, sec, tick_sec, tick_min, tick_hour, tick_day, alarm};
        expected = {exp_time, exp_strobes};
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed h=%0d m=%0d s=%0d strobes=%b, expected h=%0d m=%0d s=%0d strobes=%b",
                   tag, observed[21:17], observed[16:11], observed[10:5], observed[4:0],
                   expected[21:17], expected[16:11], expected[10:5], expected[4:0]);
        end
    endtask

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic doLoad(input int h, input int m, input int s);
        load      = 1'b1;
        load_hour = 5'(h);
        load_min  = 6'(m);
        load_sec  = 6'(s);
        applyStimulus(1);
        load      = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst        = 1'b0;
        en         = 1'b0;
        fast       = 1'b0;
        load       = 1'b0;
        load_sec   = '0;
        load_min   = '0;
        load_hour  = '0;
        alarm_en   = 1'b0;
        alarm_min  = '0;
        alarm_hour = '0;

        // Reset and first advance on the 10th edge, then every 10 edges
        applyStimulus(3);
        checkOutput("reset_state", hms(0, 0, 0), 5'b00000);
        rst = 1'b1;
        en  = 1'b1;
        applyStimulus(9);
        checkOutput("before_first_tick", hms(0, 0, 0), 5'b00000);
        applyStimulus(1);
        checkOutput("first_tick", hms(0, 0, 1), 5'b10000);
        applyStimulus(1);
        checkOutput("tick_single_cycle", hms(0, 0, 1), 5'b00000);
        applyStimulus(8);
        checkOutput("before_second_tick", hms(0, 0, 1), 5'b00000);
        applyStimulus(1);
        checkOutput("second_tick", hms(0, 0, 2), 5'b10000);

        // Full nested rollover from 23:59:58
        doLoad(23, 59, 58);
        checkOutput("load_235958", hms(23, 59, 58), 5'b00000);
        applyStimulus(10);
        checkOutput("to_235959", hms(23, 59, 59), 5'b10000);
        applyStimulus(10);
        checkOutput("day_wrap", hms(0, 0, 0), 5'b11110);
        applyStimulus(1);
        checkOutput("day_wrap_single", hms(0, 0, 0), 5'b00000);

        // Fast mode, including switch-in with prescaler above the fast limit
        doLoad(0, 0, 0);
        fast = 1'b1;
        applyStimulus(1);
        checkOutput("fast_half", hms(0, 0, 0), 5'b00000);
        applyStimulus(1);
        checkOutput("fast_tick1", hms(0, 0, 1), 5'b10000);
        applyStimulus(2);
        checkOutput("fast_tick2", hms(0, 0, 2), 5'b10000);
        fast = 1'b0;
        doLoad(0, 0, 0);
        applyStimulus(7);
        checkOutput("slow_presc7", hms(0, 0, 0), 5'b00000);
        fast = 1'b1;
        applyStimulus(1);
        checkOutput("fast_switch_wrap", hms(0, 0, 1), 5'b10000);
        applyStimulus(1);
        checkOutput("fast_switch_mid", hms(0, 0, 1), 5'b00000);
        applyStimulus(1);
        checkOutput("fast_switch_next", hms(0, 0, 2), 5'b10000);
        fast = 1'b0;

        // Pause holds prescaler and counters
        doLoad(0, 0, 0);
        applyStimulus(4);
        en = 1'b0;
        applyStimulus(25);
        checkOutput("paused_25", hms(0, 0, 0), 5'b00000);
        en = 1'b1;
        applyStimulus(5);
        checkOutput("resume_5", hms(0, 0, 0), 5'b00000);
        applyStimulus(1);
        checkOutput("resume_6", hms(0, 0, 1), 5'b10000);

        // Load clamp, load priority and load while paused
        doLoad(12, 34, 56);
        checkOutput("load_123456", hms(12, 34, 56), 5'b00000);
        doLoad(24, 60, 61);
        checkOutput("load_clamp", hms(0, 0, 0), 5'b00000);
        doLoad(23, 59, 59);
        applyStimulus(9);
        load      = 1'b1;
        load_hour = 5'd5;
        load_min  = 6'd6;
        load_sec  = 6'd7;
        applyStimulus(1);
        load      = 1'b0;
        checkOutput("load_beats_advance", hms(5, 6, 7), 5'b00000);
        applyStimulus(9);
        checkOutput("after_load_9", hms(5, 6, 7), 5'b00000);
        applyStimulus(1);
        checkOutput("after_load_10", hms(5, 6, 8), 5'b10000);
        en = 1'b0;
        doLoad(1, 2, 3);
        checkOutput("load_while_paused", hms(1, 2, 3), 5'b00000);
        en = 1'b1;

        // Asynchronous reset between edges, right after an advance
        applyStimulus(10);
        checkOutput("pre_async_reset", hms(1, 2, 4), 5'b10000);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_now", hms(0, 0, 0), 5'b00000);
        applyStimulus(1);
        checkOutput("reset_held", hms(0, 0, 0), 5'b00000);
        rst = 1'b1;

        // Alarm at 00:01
        alarm_min  = 6'd1;
        alarm_hour = 5'd0;
        alarm_en   = 1'b1;
        doLoad(0, 0, 59);
        checkOutput("alarm_load", hms(0, 0, 59), 5'b00000);
        applyStimulus(10);
        checkOutput("alarm_fire", hms(0, 1, 0), 5'b11001);
        applyStimulus(1);
        checkOutput("alarm_single", hms(0, 1, 0), 5'b00000);
        alarm_en = 1'b0;
        doLoad(0, 0, 59);
        applyStimulus(10);
        checkOutput("alarm_disabled", hms(0, 1, 0), 5'b11000);
        alarm_en = 1'b1;
        doLoad(0, 1, 0);
        checkOutput("alarm_on_load", hms(0, 1, 0), 5'b00000);
        applyStimulus(10);
        checkOutput("alarm_not_sec0", hms(0, 1, 1), 5'b10000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
